// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Datapath mux selects, ALU codes, DP commands and condition codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    function automatic logic [3:0] cmd_to_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR};
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control unit <-> datapath bundle.
// master is the sequencer, slave is the datapath side.
interface multicycle_control_unit_if;

    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        pc_we;
    logic        ir_we;
    logic        mem_we;
    logic        reg_we;
    logic        adr_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  imm_src;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [3:0]  flags;
    logic        retire;
    logic        halted;

    modport master (
        input  instr, alu_flags, mem_ready,
        output pc_we, ir_we, mem_we, reg_we, adr_src,
        output alu_src_a, alu_src_b, imm_src, result_src,
        output alu_control, flags, retire, halted
    );

    modport slave (
        output instr, alu_flags, mem_ready,
        input  pc_we, ir_we, mem_we, reg_we, adr_src,
        input  alu_src_a, alu_src_b, imm_src, result_src,
        input  alu_control, flags, retire, halted
    );

endinterface

// File: rtl/multicycle_control_unit_cond_check.sv
// ARM condition-code evaluation against registered NZCV.
// Purely combinational; NV (1111) never passes.
module cond_check
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ok
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    always_comb begin
        o_cond_ok = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ok = w_z;
            COND_NE: o_cond_ok = !w_z;
            COND_CS: o_cond_ok = w_c;
            COND_CC: o_cond_ok = !w_c;
            COND_MI: o_cond_ok = w_n;
            COND_PL: o_cond_ok = !w_n;
            COND_VS: o_cond_ok = w_v;
            COND_VC: o_cond_ok = !w_v;
            COND_HI: o_cond_ok = w_c && !w_z;
            COND_LS: o_cond_ok = !w_c || w_z;
            COND_GE: o_cond_ok = (w_n == w_v);
            COND_LT: o_cond_ok = (w_n != w_v);
            COND_GT: o_cond_ok = !w_z && (w_n == w_v);
            COND_LE: o_cond_ok = w_z || (w_n != w_v);
            COND_AL: o_cond_ok = 1'b1;
            default: o_cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer: steps fetch/decode/execute/memory/writeback and
// drives every datapath enable and select; owns the NZCV register.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    multicycle_control_unit_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       w_cond_ok;

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic [3:0] w_rd;
    logic       w_i, w_s, w_u;
    logic       w_is_cmp, w_arith, w_exec, w_unused;

    logic       w_pc_we, w_ir_we, w_mem_we, w_reg_we, w_adr_src;
    logic [1:0] w_src_a, w_src_b, w_imm_src, w_res_src;
    logic [3:0] w_alu;
    logic       w_retire, w_halted;

    assign w_op     = bus.instr[27:26];
    assign w_i      = bus.instr[25];
    assign w_cmd    = bus.instr[24:21];
    assign w_u      = bus.instr[23];
    assign w_s      = bus.instr[20];
    assign w_rd     = bus.instr[15:12];
    assign w_unused = ^{bus.instr[19:16], bus.instr[11:0]};

    assign w_is_cmp = (w_cmd == CMD_CMP);
    assign w_arith  = w_cmd inside {CMD_ADD, CMD_SUB, CMD_CMP};
    assign w_exec   = (r_state == S_EXECR) || (r_state == S_EXECI);

    cond_check u_cond (
        .i_cond    (bus.instr[31:28]),
        .i_flags   (r_flags),
        .o_cond_ok (w_cond_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Logical ops leave C and V untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_cond_ok && (w_s || w_is_cmp)) begin
            r_flags[3:2] <= bus.alu_flags[3:2];
            if (w_arith) r_flags[1:0] <= bus.alu_flags[1:0];
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_we   = 1'b0;
        w_ir_we   = 1'b0;
        w_mem_we  = 1'b0;
        w_reg_we  = 1'b0;
        w_adr_src = 1'b0;
        w_src_a   = SRCA_RN;
        w_src_b   = SRCB_RM;
        w_imm_src = IMM_DP;
        w_res_src = RES_ALUOUT;
        w_alu     = ALU_ADD;
        w_retire  = 1'b0;
        w_halted  = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_src_a   = SRCA_PC;
                w_src_b   = SRCB_FOUR;
                w_res_src = RES_ALU;
                if (bus.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_src_a = SRCA_PC;
                w_src_b = SRCB_FOUR;
                if (!w_cond_ok) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    case (w_op)
                        OP_DP: begin
                            if (!cmd_valid(w_cmd)) w_next = S_HALT;
                            else if (w_i)          w_next = S_EXECI;
                            else                   w_next = S_EXECR;
                        end
                        OP_MEM:  w_next = S_MEMADR;
                        OP_BR:   w_next = S_BRANCH;
                        default: w_next = S_HALT;
                    endcase
                end
            end
            S_EXECR: begin
                w_alu  = cmd_to_alu(w_cmd);
                w_next = S_ALUWB;
            end
            S_EXECI: begin
                w_src_b = SRCB_IMM;
                w_alu   = cmd_to_alu(w_cmd);
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                if (!w_is_cmp) begin
                    if (w_rd == 4'hF) w_pc_we  = 1'b1;
                    else              w_reg_we = 1'b1;
                end
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMADR: begin
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_MEM;
                w_alu     = w_u ? ALU_ADD : ALU_SUB;
                w_next    = w_s ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_adr_src = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_res_src = RES_MEM;
                w_reg_we  = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                w_adr_src = 1'b1;
                w_mem_we  = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_src_a   = SRCA_ALUOUT;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_BR;
                w_res_src = RES_ALU;
                w_pc_we   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT:  w_halted = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ir_we       = w_ir_we;
    assign bus.mem_we      = w_mem_we;
    assign bus.reg_we      = w_reg_we;
    assign bus.adr_src     = w_adr_src;
    assign bus.alu_src_a   = w_src_a;
    assign bus.alu_src_b   = w_src_b;
    assign bus.imm_src     = w_imm_src;
    assign bus.result_src  = w_res_src;
    assign bus.alu_control = w_alu;
    assign bus.flags       = r_flags;
    assign bus.retire      = w_retire;
    assign bus.halted      = w_halted;

endmodule
